paint_ctrl: RTL and testbench

Parametrised paint control unit for the drawing-board design. It owns a cursor that moves over a W×H canvas at a programmable rate. It writes brush squares or a full-canvas clear into the framebuffer's write port, and exports the cursor position to the display controller. It replaces the fixed 256×256, divided-clock painter. Everything runs on the system clock, with an internal move-rate enable.

---
 rtl/paint_pkg.sv | 50 +++++
 rtl/paint_ctrl_move_tick.sv | 33 +++
 rtl/paint_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_paint_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// ----------------------------------------------------------------------------
// paint_pkg
// Shared definitions for the paint control unit:
//   - state_t       : controller states (IDLE / BRUSH / CLEAR)
//   - DIR_*         : bit positions inside the 4-bit direction input
//   - pix_addr()    : linear framebuffer address, row*width + col
//   - cursor_step() : one cursor step along an axis, clamping or wrapping
// No ports; imported by paint_ctrl.
// ----------------------------------------------------------------------------
package paint_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BRUSH = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Computed at 32 bits; callers truncate to their X_W+Y_W address width,
    // which always holds any on-canvas address.
    function automatic logic [31:0] pix_addr(input logic [31:0] row,
                                             input logic [31:0] col,
                                             input logic [31:0] hpix);
        return row * hpix + col;
    endfunction

    // Opposing requests cancel. At an edge the position either saturates or
    // wraps to the opposite edge depending on 'wrap'.
    function automatic logic [31:0] cursor_step(input logic [31:0] pos,
                                                input logic        dec,
                                                input logic        inc,
                                                input logic [31:0] max_pos,
                                                input logic        wrap);
        logic [31:0] res;
        res = pos;
        if (dec && !inc) begin
            if (pos == 32'd0) res = wrap ? max_pos : 32'd0;
            else              res = pos - 32'd1;
        end else if (inc && !dec) begin
            if (pos == max_pos) res = wrap ? 32'd0 : max_pos;
            else                res = pos + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/paint_ctrl_move_tick.sv
// ----------------------------------------------------------------------------
// move_tick
// Free-running divider producing the cursor movement-rate enable.
//   clk    : system clock
//   rst_n  : synchronous active-high reset (counter returns to 0)
//   o_tick : high for one cycle whenever the count equals MOVE_DIV-1
// ----------------------------------------------------------------------------
module move_tick #(
    parameter int MOVE_DIV = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/paint_ctrl.sv
// ----------------------------------------------------------------------------
// paint_ctrl
// Cursor + brush/clear engine driving a framebuffer write port.
//   clk    in  : system clock
//   rst_n  in  : synchronous active-high reset
//   rgb    in  : brush colour (captured when a brush starts)
//   dir    in  : [0] up, [1] down, [2] left, [3] right
//   draw   in  : paint a brush square at the cursor on a movement tick
//   clear  in  : one-cycle request to fill the whole canvas with CLEAR_COLOR
//   brush  in  : brush side length minus one (side 1..4)
//   x, y   out : cursor column / row
//   we     out : framebuffer write enable
//   waddr  out : framebuffer address (row*H_PIX + col)
//   wdata  out : framebuffer write data
//   busy   out : high while a brush or clear operation is emitting pixels
// All outputs are registered.
// ----------------------------------------------------------------------------
module paint_ctrl
    import paint_pkg::*;
#(
    parameter int H_PIX    = 256,
    parameter int V_PIX    = 256,
    parameter int X_W      = 8,
    parameter int Y_W      = 8,
    parameter int COLOR_W  = 12,
    parameter int MOVE_DIV = 10000000,
    parameter int WRAP     = 0,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = 12'hFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COLOR_W-1:0]   rgb,
    input  logic [3:0]           dir,
    input  logic                 draw,
    input  logic                 clear,
    input  logic [1:0]           brush,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic                 we,
    output logic [X_W+Y_W-1:0]   waddr,
    output logic [COLOR_W-1:0]   wdata,
    output logic                 busy
);

    localparam int AW = X_W + Y_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(H_PIX * V_PIX - 1);

    state_t              r_state, r_state_next;
    logic [X_W-1:0]      r_x, r_x_next;
    logic [Y_W-1:0]      r_y, r_y_next;
    logic [X_W-1:0]      r_ax, r_ax_next;        // brush anchor column
    logic [Y_W-1:0]      r_ay, r_ay_next;        // brush anchor row
    logic [COLOR_W-1:0]  r_color, r_color_next;
    logic [1:0]          r_size, r_size_next;    // side length minus one
    logic [1:0]          r_dx, r_dx_next;        // offset of the next pixel to emit
    logic [1:0]          r_dy, r_dy_next;
    logic                r_done, r_done_next;    // last pixel/address already emitted
    logic [AW-1:0]       r_cnt, r_cnt_next;      // next clear address
    logic                r_we, r_we_next;
    logic [AW-1:0]       r_waddr, r_waddr_next;
    logic [COLOR_W-1:0]  r_wdata, r_wdata_next;
    logic                r_busy, r_busy_next;

    logic                w_tick;
    logic [X_W-1:0]      w_x_step;
    logic [Y_W-1:0]      w_y_step;
    logic [X_W+1:0]      w_col;
    logic [Y_W+1:0]      w_row;
    logic                w_on;
    logic                w_last_dx;
    logic                w_last_px;

    move_tick #(
        .MOVE_DIV (MOVE_DIV)
    ) u_move_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_x_step = X_W'(cursor_step(32'(r_x), dir[DIR_LEFT], dir[DIR_RIGHT],
                                       32'(H_PIX - 1), WRAP != 0));
    assign w_y_step = Y_W'(cursor_step(32'(r_y), dir[DIR_UP], dir[DIR_DOWN],
                                       32'(V_PIX - 1), WRAP != 0));

    // Brush pixels are computed two bits wider so positions past the right or
    // bottom edge are detected and suppressed instead of wrapping.
    assign w_col = (X_W+2)'(r_ax) + (X_W+2)'(r_dx);
    assign w_row = (Y_W+2)'(r_ay) + (Y_W+2)'(r_dy);
    assign w_on  = (w_col < (X_W+2)'(H_PIX)) && (w_row < (Y_W+2)'(V_PIX));

    assign w_last_dx = (r_dx == r_size);
    assign w_last_px = w_last_dx && (r_dy == r_size);

    always_comb begin
        r_state_next = r_state;
        r_x_next     = r_x;
        r_y_next     = r_y;
        r_ax_next    = r_ax;
        r_ay_next    = r_ay;
        r_color_next = r_color;
        r_size_next  = r_size;
        r_dx_next    = r_dx;
        r_dy_next    = r_dy;
        r_done_next  = r_done;
        r_cnt_next   = r_cnt;
        r_we_next    = 1'b0;
        r_waddr_next = r_waddr;
        r_wdata_next = r_wdata;
        r_busy_next  = r_busy;

        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    // Address 0 goes out on this edge; r_cnt points at the next one.
                    r_state_next = ST_CLEAR;
                    r_we_next    = 1'b1;
                    r_waddr_next = '0;
                    r_wdata_next = CLEAR_COLOR;
                    r_busy_next  = 1'b1;
                    r_cnt_next   = AW'(1);
                    r_done_next  = (LAST_ADDR == '0);
                end else if (w_tick) begin
                    r_x_next = w_x_step;
                    r_y_next = w_y_step;
                    if (draw) begin
                        // Pixel (0,0) sits on the post-move cursor, so it is
                        // always on the canvas and is emitted right away.
                        r_state_next = ST_BRUSH;
                        r_ax_next    = w_x_step;
                        r_ay_next    = w_y_step;
                        r_color_next = rgb;
                        r_size_next  = brush;
                        r_we_next    = 1'b1;
                        r_waddr_next = AW'(pix_addr(32'(w_y_step), 32'(w_x_step), 32'(H_PIX)));
                        r_wdata_next = rgb;
                        r_busy_next  = 1'b1;
                        r_dx_next    = (brush == 2'd0) ? 2'd0 : 2'd1;
                        r_dy_next    = 2'd0;
                        r_done_next  = (brush == 2'd0);
                    end
                end
            end

            ST_BRUSH: begin
                if (r_done) begin
                    r_state_next = ST_IDLE;
                    r_busy_next  = 1'b0;
                end else begin
                    r_we_next = w_on;
                    if (w_on) begin
                        r_waddr_next = AW'(pix_addr(32'(w_row), 32'(w_col), 32'(H_PIX)));
                        r_wdata_next = r_color;
                    end
                    if (w_last_dx) begin
                        r_dx_next = 2'd0;
                        r_dy_next = r_dy + 2'd1;
                    end else begin
                        r_dx_next = r_dx + 2'd1;
                    end
                    r_done_next = w_last_px;
                end
            end

            ST_CLEAR: begin
                if (r_done) begin
                    r_state_next = ST_IDLE;
                    r_busy_next  = 1'b0;
                end else begin
                    r_we_next    = 1'b1;
                    r_waddr_next = r_cnt;
                    r_wdata_next = CLEAR_COLOR;
                    r_cnt_next   = r_cnt + AW'(1);
                    r_done_next  = (r_cnt == LAST_ADDR);
                end
            end

            default: begin
                r_state_next = ST_IDLE;
                r_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= X_W'(H_PIX / 2);
            r_y     <= Y_W'(V_PIX / 2);
            r_ax    <= '0;
            r_ay    <= '0;
            r_color <= '0;
            r_size  <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= r_state_next;
            r_x     <= r_x_next;
            r_y     <= r_y_next;
            r_ax    <= r_ax_next;
            r_ay    <= r_ay_next;
            r_color <= r_color_next;
            r_size  <= r_size_next;
            r_dx    <= r_dx_next;
            r_dy    <= r_dy_next;
            r_done  <= r_done_next;
            r_cnt   <= r_cnt_next;
            r_we    <= r_we_next;
            r_waddr <= r_waddr_next;
            r_wdata <= r_wdata_next;
            r_busy  <= r_busy_next;
        end
    end

    assign x     = r_x;
    assign y     = r_y;
    assign we    = r_we;
    assign waddr = r_waddr;
    assign wdata = r_wdata;
    assign busy  = r_busy;

endmodule

// File: tb/tb_paint_ctrl.sv
// ----------------------------------------------------------------------------
// tb_paint_ctrl
// Two paint_ctrl instances on a 16x12 canvas (MOVE_DIV=4), one clamping and
// one wrapping, share all inputs. The driver keeps an operation-level model
// (cursor positions, busy windows, expected write list per instance) and
// pushes expected writes/busy windows into queues; a negedge monitor pops and
// compares whatever the instances present.
// ----------------------------------------------------------------------------
module tb_paint_ctrl;

    localparam int H   = 16;
    localparam int V   = 12;
    localparam int XW  = 4;
    localparam int YW  = 4;
    localparam int CW  = 12;
    localparam int DIV = 4;
    localparam int HV  = H * V;

    typedef struct {
        int at;      // edge index after which the write is visible
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int start;   // busy visible after edges start .. stop-1
        int stop;
    } bz_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [CW-1:0] rgb   = '0;
    logic [3:0]    dir   = '0;
    logic          draw  = 1'b0;
    logic          clear = 1'b0;
    logic [1:0]    brush = '0;

    logic [XW-1:0]    m_x     [2];
    logic [YW-1:0]    m_y     [2];
    logic             m_we    [2];
    logic [XW+YW-1:0] m_waddr [2];
    logic [CW-1:0]    m_wdata [2];
    logic             m_busy  [2];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            paint_ctrl #(
                .H_PIX       (H),
                .V_PIX       (V),
                .X_W         (XW),
                .Y_W         (YW),
                .COLOR_W     (CW),
                .MOVE_DIV    (DIV),
                .WRAP        (gi),
                .CLEAR_COLOR (12'hFFF)
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .rgb   (rgb),
                .dir   (dir),
                .draw  (draw),
                .clear (clear),
                .brush (brush),
                .x     (m_x[gi]),
                .y     (m_y[gi]),
                .we    (m_we[gi]),
                .waddr (m_waddr[gi]),
                .wdata (m_wdata[gi]),
                .busy  (m_busy[gi])
            );
        end
    endgenerate

    int  n_checks = 0;
    int  n_errors = 0;
    int  edge_n   = 0;
    bit  mon_en   = 1'b0;

    wr_t exp_q [2][$];
    bz_t bq[$];

    int  mx [2];
    int  my [2];
    int  ph;
    int  busy_end;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin : mon
        wr_t w;
        int  n;
        int  eb;
        if (mon_en) begin
            n = edge_n;
            for (int d = 0; d < 2; d++) begin
                while (exp_q[d].size() > 0 && exp_q[d][0].at < n) begin
                    w = exp_q[d].pop_front();
                    n_checks++;
                    n_errors++;
                    $display("FAIL missed_write dut%0d: addr %0d never written, expected after edge %0d",
                             d, w.addr, w.at);
                end
                if (m_we[d] === 1'b1) begin
                    if (exp_q[d].size() > 0 && exp_q[d][0].at == n) begin
                        w = exp_q[d].pop_front();
                        $display("dut%0d write edge %0d addr %0d data %03h", d, n, m_waddr[d], m_wdata[d]);
                        check($sformatf("waddr_dut%0d", d), int'(m_waddr[d]), w.addr);
                        check($sformatf("wdata_dut%0d", d), int'(m_wdata[d]), w.data);
                    end else begin
                        check($sformatf("unexpected_we_dut%0d_addr%0d", d, m_waddr[d]), int'(m_we[d]), 0);
                    end
                end else if (exp_q[d].size() > 0 && exp_q[d][0].at == n) begin
                    w = exp_q[d].pop_front();
                    check($sformatf("we_dut%0d_addr%0d", d, w.addr), int'(m_we[d]), 1);
                end
            end
            while (bq.size() > 0 && bq[0].stop <= n) void'(bq.pop_front());
            eb = (bq.size() > 0 && bq[0].start <= n) ? 1 : 0;
            for (int d = 0; d < 2; d++)
                check($sformatf("busy_dut%0d", d), int'(m_busy[d]), eb);
        end
    end

    // ------------------------------------------------------------ model
    task automatic model_reset(input int e);
        bz_t b;
        ph       = 0;
        busy_end = e;
        for (int d = 0; d < 2; d++) begin
            mx[d] = H / 2;
            my[d] = V / 2;
            while (exp_q[d].size() > 0 && exp_q[d][exp_q[d].size()-1].at >= e)
                void'(exp_q[d].pop_back());
        end
        while (bq.size() > 0 && bq[bq.size()-1].start >= e) void'(bq.pop_back());
        if (bq.size() > 0 && bq[bq.size()-1].stop > e) begin
            b = bq.pop_back();
            b.stop = e;
            bq.push_back(b);
        end
    endtask

    task automatic model_move(input logic [3:0] d);
        int sx, sy, nx, ny;
        sx = (d[3] ? 1 : 0) - (d[2] ? 1 : 0);
        sy = (d[1] ? 1 : 0) - (d[0] ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            nx = mx[k] + sx;
            ny = my[k] + sy;
            if (k == 1) begin
                mx[k] = (nx + H) % H;
                my[k] = (ny + V) % V;
            end else begin
                mx[k] = (nx < 0) ? 0 : (nx > H-1) ? H-1 : nx;
                my[k] = (ny < 0) ? 0 : (ny > V-1) ? V-1 : ny;
            end
        end
    endtask

    task automatic model_brush(input int e, input logic [1:0] br, input logic [CW-1:0] col);
        int s, c, r;
        wr_t w;
        bz_t b;
        s = int'(br) + 1;
        for (int k = 0; k < 2; k++)
            for (int dy = 0; dy < s; dy++)
                for (int dx = 0; dx < s; dx++) begin
                    c = mx[k] + dx;
                    r = my[k] + dy;
                    if (c < H && r < V) begin
                        w.at = e + dy * s + dx; w.addr = r * H + c; w.data = int'(col);
                        exp_q[k].push_back(w);
                    end
                end
        b.start = e; b.stop = e + s * s;
        bq.push_back(b);
        busy_end = e + s * s;
    endtask

    task automatic model_clear(input int e);
        wr_t w;
        bz_t b;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < HV; a++) begin
                w.at = e + a; w.addr = a; w.data = 12'hFFF;
                exp_q[k].push_back(w);
            end
        b.start = e; b.stop = e + HV;
        bq.push_back(b);
        busy_end = e + HV;
    endtask

    // ------------------------------------------------------------ driver
    task automatic cyc(input logic [3:0] d, input logic dr, input logic cl,
                       input logic [1:0] br, input logic [CW-1:0] col, input logic rs);
        int e;
        @(negedge clk);
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("x_dut%0d", k), int'(m_x[k]), mx[k]);
                check($sformatf("y_dut%0d", k), int'(m_y[k]), my[k]);
            end
        end
        dir = d; draw = dr; clear = cl; brush = br; rgb = col; rst_n = rs;
        e = edge_n + 1;
        if (rs) begin
            model_reset(e);
        end else begin
            if (e > busy_end) begin
                if (cl) begin
                    model_clear(e);
                end else if (ph == DIV - 1) begin
                    model_move(d);
                    if (dr) model_brush(e, br, col);
                end
            end
            ph = (ph + 1) % DIV;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(4'b0000, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    endtask

    // Idles until the next cycle is an accepted tick, then drives that cycle.
    task automatic go_tick(input logic [3:0] d, input logic dr, input logic cl,
                           input logic [1:0] br, input logic [CW-1:0] col);
        for (int k = 0; k < 1000 && !(ph == DIV - 1 && edge_n + 2 > busy_end); k++)
            idle(1);
        cyc(d, dr, cl, br, col, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) cyc(4'b0000, 1'b0, 1'b0, 2'd0, '0, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_we_dut%0d", k),    int'(m_we[k]),    0);
            check($sformatf("rst_busy_dut%0d", k),  int'(m_busy[k]),  0);
            check($sformatf("rst_waddr_dut%0d", k), int'(m_waddr[k]), 0);
            check($sformatf("rst_wdata_dut%0d", k), int'(m_wdata[k]), 0);
            check($sformatf("rst_x_dut%0d", k),     int'(m_x[k]),     H / 2);
            check($sformatf("rst_y_dut%0d", k),     int'(m_y[k]),     V / 2);
        end
    endtask

    initial begin
        logic [3:0]    rd;
        logic [CW-1:0] rc;
        ph = 0; busy_end = 0;
        for (int k = 0; k < 2; k++) begin mx[k] = H / 2; my[k] = V / 2; end

        do_reset(2);
        mon_en = 1'b1;

        // Cursor: clamp/wrap on every edge, cancelling opposite directions.
        for (int k = 0; k < 80;  k++) cyc(4'b0100, 1'b0, 1'b0, 2'd0, '0, 1'b0);
        for (int k = 0; k < 12;  k++) cyc(4'b1100, 1'b0, 1'b0, 2'd0, '0, 1'b0);
        for (int k = 0; k < 12;  k++) cyc(4'b0011, 1'b0, 1'b0, 2'd0, '0, 1'b0);
        for (int k = 0; k < 60;  k++) cyc(4'b0001, 1'b0, 1'b0, 2'd0, '0, 1'b0);
        for (int k = 0; k < 100; k++) cyc(4'b1010, 1'b0, 1'b0, 2'd0, '0, 1'b0);

        // 4x4 brush in the bottom-right corner (clipped), draw held while busy.
        go_tick(4'b0000, 1'b1, 1'b0, 2'd3, 12'h0F0);
        for (int k = 0; k < 24; k++) cyc(4'b0101, 1'b1, 1'b0, 2'd1, 12'h00F, 1'b0);

        // Clear on a tick cycle with draw set; extra clear/draw during the sweep.
        go_tick(4'b1000, 1'b1, 1'b1, 2'd3, 12'h0F0);
        for (int k = 0; k < HV + 8; k++)
            cyc(4'b1000, 1'b1, (k % 50) == 7, 2'd2, 12'h123, 1'b0);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            rd = 4'($urandom);
            rc = CW'($urandom);
            cyc(rd, 1'($urandom), ($urandom_range(0, 299) == 0), 2'($urandom), rc, 1'b0);
        end

        // Reset on the third brush cycle: only three pixels may appear.
        go_tick(4'b0000, 1'b1, 1'b0, 2'd3, 12'hABC);
        idle(2);
        do_reset(1);
        idle(20);

        for (int k = 0; k < 2; k++)
            check($sformatf("pending_writes_dut%0d", k), exp_q[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
